// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller owning the MIPS32 HI/LO register pair.
// Define MULDIV_MADD_EN to add the madd/maddu/msub/msubu accumulate operations.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        UseMD_D,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Stall_MD
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic [31:0]     hi_r, hi_nx_s, lo_r, lo_nx_s;
    logic [31:0]     a_r, a_nx_s, b_r, b_nx_s;
    logic            sgn_r, sgn_nx_s;
    logic            busy_r;
    logic [63:0]     prod_s, div_s, mul_res_s;
`ifdef MULDIV_MADD_EN
    logic            acc_r, acc_nx_s, sub_r, sub_nx_s;
`endif

    // Full 64-bit product; sign-extending first makes the low 64 bits exact for signed operands.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // Magnitude division keeps 0x80000000 / -1 well defined; returns {remainder, quotient}.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic        na;
        logic        nb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        q  = (mb == 32'd0) ? 32'd0 : (ma / mb);
        r  = (mb == 32'd0) ? 32'd0 : (ma % mb);
        q  = (na ^ nb) ? (32'd0 - q) : q;
        r  = na ? (32'd0 - r) : r;
        return {r, q};
    endfunction

    assign prod_s = mul64(a_r, b_r, sgn_r);
    assign div_s  = div64(a_r, b_r, sgn_r);

    // Multiply write-back value, optionally accumulated onto the current HI/LO.
    always_comb begin
`ifdef MULDIV_MADD_EN
        if (!acc_r) begin
            mul_res_s = prod_s;
        end else if (sub_r) begin
            mul_res_s = {hi_r, lo_r} - prod_s;
        end else begin
            mul_res_s = {hi_r, lo_r} + prod_s;
        end
`else
        mul_res_s = prod_s;
`endif
    end

    // Next-state logic: issue decode in IDLE, countdown and write-back in MUL/DIV.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        hi_nx_s    = hi_r;
        lo_nx_s    = lo_r;
        a_nx_s     = a_r;
        b_nx_s     = b_r;
        sgn_nx_s   = sgn_r;
`ifdef MULDIV_MADD_EN
        acc_nx_s   = acc_r;
        sub_nx_s   = sub_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    case (Op)
                        4'd0, 4'd1: begin
                            state_nx_s = ST_MUL;
                            cnt_nx_s   = CNT_MUL;
                            a_nx_s     = A;
                            b_nx_s     = B;
                            sgn_nx_s   = ~Op[0];
`ifdef MULDIV_MADD_EN
                            acc_nx_s   = 1'b0;
                            sub_nx_s   = 1'b0;
`endif
                        end
`ifdef MULDIV_MADD_EN
                        4'd6, 4'd7, 4'd8, 4'd9: begin
                            state_nx_s = ST_MUL;
                            cnt_nx_s   = CNT_MUL;
                            a_nx_s     = A;
                            b_nx_s     = B;
                            sgn_nx_s   = ~Op[0];
                            acc_nx_s   = 1'b1;
                            sub_nx_s   = Op[3];
                        end
`endif
                        4'd2, 4'd3: begin
                            state_nx_s = ST_DIV;
                            cnt_nx_s   = CNT_DIV;
                            a_nx_s     = A;
                            b_nx_s     = B;
                            sgn_nx_s   = ~Op[0];
                        end
                        4'd4:    hi_nx_s = A;
                        4'd5:    lo_nx_s = A;
                        default: state_nx_s = ST_IDLE;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                cnt_nx_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_IDLE;
                    {hi_nx_s, lo_nx_s} = mul_res_s;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            ST_DIV: begin
                cnt_nx_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_IDLE;
                    // A zero divisor still burns the window but leaves HI/LO alone.
                    if (b_r != 32'd0) begin
                        {hi_nx_s, lo_nx_s} = div_s;
                    end else begin
                        {hi_nx_s, lo_nx_s} = {hi_r, lo_r};
                    end
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // State register with synchronous active-low reset; in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sgn_r   <= 1'b0;
            busy_r  <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_r   <= 1'b0;
            sub_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            hi_r    <= hi_nx_s;
            lo_r    <= lo_nx_s;
            a_r     <= a_nx_s;
            b_r     <= b_nx_s;
            sgn_r   <= sgn_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
`ifdef MULDIV_MADD_EN
            acc_r   <= acc_nx_s;
            sub_r   <= sub_nx_s;
`endif
        end
    end

    assign Busy     = busy_r;
    assign HI       = hi_r;
    assign LO       = lo_r;
    assign Stall_MD = UseMD_D & (busy_r | Start);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, corner sequences, and
// randomized operations against an arithmetic reference model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        UseMD_D;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Stall_MD;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .UseMD_D(UseMD_D), .Busy(Busy), .HI(HI), .LO(LO), .Stall_MD(Stall_MD)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a one-cycle issue strobe; called just after a falling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Op = 4'd15;
    endtask

    // Count busy cycles, ending at the falling edge of the first idle cycle.
    task automatic run_window(output int n);
        n = 0;
        @(negedge clk);
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Reference model: spec arithmetic on 64-bit integers.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 0;
        case (op)
            4'd0: begin p = sa * sb; {hi_m, lo_m} = p; lat = 5; end
            4'd1: begin p = ua * ub; {hi_m, lo_m} = p; lat = 5; end
            4'd2: begin
                lat = 10;
                if (b != 32'd0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            end
            4'd3: begin
                lat = 10;
                if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
            end
            4'd4: hi_m = a;
            4'd5: lo_m = a;
`ifdef MULDIV_MADD_EN
            4'd6: begin p = sa * sb; {hi_m, lo_m} = {hi_m, lo_m} + p; lat = 5; end
            4'd7: begin p = ua * ub; {hi_m, lo_m} = {hi_m, lo_m} + p; lat = 5; end
            4'd8: begin p = sa * sb; {hi_m, lo_m} = {hi_m, lo_m} - p; lat = 5; end
            4'd9: begin p = ua * ub; {hi_m, lo_m} = {hi_m, lo_m} - p; lat = 5; end
`endif
            default: lat = 0;
        endcase
    endtask

    initial begin
        int n;
        int lat;
        logic [3:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic use_d;

        tbl[0] = '{4'd0,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        tbl[1] = '{4'd1,  32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 5};
        tbl[2] = '{4'd2,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3] = '{4'd3,  32'd7,        32'd2,        32'd1,        32'd3,        10};
        tbl[4] = '{4'd4,  32'h12345678, 32'd0,        32'h12345678, 32'd3,        0};
        tbl[5] = '{4'd5,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[6] = '{4'd2,  32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 10};
        tbl[7] = '{4'd2,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        tbl[8] = '{4'd12, 32'h11111111, 32'h22222222, 32'd0,        32'h80000000, 0};
        tbl[9] = '{4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

        reset = 1'b0; Start = 1'b0; Op = 4'd15; A = 32'd0; B = 32'd0; UseMD_D = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_stall", {31'd0, Stall_MD}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            run_window(n);
            check($sformatf("tbl%0d_busy_cycles", i), n, tbl[i].lat);
            check($sformatf("tbl%0d_hi", i), HI, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), LO, tbl[i].lo);
        end

        // divu with UseMD_D held; a stray mthi mid-window must be ignored.
        UseMD_D = 1'b1; Op = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
        #1 check("stall_issue", {31'd0, Stall_MD}, 32'd1);
        @(posedge clk); #1 Start = 1'b0; Op = 4'd15;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Busy !== 1'b1) break;
            n++;
            check("stall_busy", {31'd0, Stall_MD}, 32'd1);
            if (n == 5) begin
                Op = 4'd4; A = 32'hDEADBEEF; Start = 1'b1;
                @(posedge clk); #1 Start = 1'b0; Op = 4'd15;
            end
        end
        check("stall_window_len", n, 32'd10);
        check("stall_after", {31'd0, Stall_MD}, 32'd0);
        check("stall_div_hi", HI, 32'd2);
        check("stall_div_lo", LO, 32'd14);
        UseMD_D = 1'b0;

        // Reset in the third busy cycle of a mult discards the result.
        issue(4'd0, 32'd7, 32'd9);
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'd0, Busy}, 32'd0);
        check("midreset_hi", HI, 32'd0);
        check("midreset_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("midreset_late_hi", HI, 32'd0);
        check("midreset_late_lo", LO, 32'd0);
        check("midreset_late_busy", {31'd0, Busy}, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;

`ifdef MULDIV_MADD_EN
        issue(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'd10, 32'd0);
        issue(4'd6, 32'd3, 32'd4);
        run_window(n);
        check("madd_busy_cycles", n, 32'd5);
        check("madd_hi", HI, 32'd0);
        check("madd_lo", LO, 32'd22);
        issue(4'd9, 32'd1, 32'd30);
        run_window(n);
        check("msubu_hi", HI, 32'hFFFFFFFF);
        check("msubu_lo", LO, 32'hFFFFFFF8);
        hi_m = 32'hFFFFFFFF; lo_m = 32'hFFFFFFF8;
`endif

        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            use_d = 1'($urandom_range(0, 1));
            UseMD_D = use_d; Op = rop; A = ra; B = rb; Start = 1'b1;
            #1 check("rnd_stall_issue", {31'd0, Stall_MD}, {31'd0, use_d});
            @(posedge clk); #1 Start = 1'b0; Op = 4'd15; UseMD_D = 1'b0;
            model(rop, ra, rb, lat);
            run_window(n);
            check($sformatf("rnd%0d_op%0d_busy_cycles", i, rop), n, lat);
            check($sformatf("rnd%0d_op%0d_hi", i, rop), HI, hi_m);
            check($sformatf("rnd%0d_op%0d_lo", i, rop), LO, lo_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
